// File: rtl/ext_pkg.sv
// ext_pkg
//   Shared definitions for the pipelined extension unit:
//   - ext_op encodings (EXT_ZEXT .. EXT_LW)
//   - skid-buffer state encoding (EMPTY / ONE / FULL)
//   - buffered payload record (result data, tag, misalign flag)
//   The payload is sized for the widest legal configuration; narrower
//   instances use the low bits of each field.
package ext_pkg;

  localparam logic [2:0] EXT_ZEXT = 3'd0;
  localparam logic [2:0] EXT_SEXT = 3'd1;
  localparam logic [2:0] EXT_LUI  = 3'd2;
  localparam logic [2:0] EXT_LB   = 3'd3;
  localparam logic [2:0] EXT_LBU  = 3'd4;
  localparam logic [2:0] EXT_LH   = 3'd5;
  localparam logic [2:0] EXT_LHU  = 3'd6;
  localparam logic [2:0] EXT_LW   = 3'd7;

  localparam int EXT_MAX_DATA_W = 64;
  localparam int EXT_MAX_TAG_W  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [EXT_MAX_DATA_W-1:0] data;
    logic [EXT_MAX_TAG_W-1:0]  tag;
    logic                      misalign;
  } ext_payload_t;

endpackage

// File: rtl/ext_compute.sv
// ext_compute
//   Purely combinational immediate / load-data extender.
//   Ports:
//     ext_op   - operation select (ext_pkg EXT_* encodings)
//     data     - immediate in [IMM_W-1:0] for ops 0-2, memory word for loads
//     offset   - byte offset within the word (loads only)
//     result   - extended value (zero on a misaligned load)
//     misalign - load offset not naturally aligned for its size
module ext_compute
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        ext_op,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] result,
  output logic              misalign
);

  logic [IMM_W-1:0] imm;
  logic [15:0]      half_v;
  logic [7:0]       byte_v;

  assign imm = data[IMM_W-1:0];

  // Little-endian lanes: shifting right by offset*8 brings the addressed
  // byte to bit 0; only the low halfword is ever needed.
  assign half_v = 16'(data >> {offset, 3'b000});
  assign byte_v = half_v[7:0];

  always_comb begin
    result   = '0;
    misalign = 1'b0;
    case (ext_op)
      EXT_ZEXT: result = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SEXT: result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_LUI:  result = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_LB:   result = {{(DATA_W-8){byte_v[7]}}, byte_v};
      EXT_LBU:  result = {{(DATA_W-8){1'b0}}, byte_v};
      EXT_LH: begin
        if (offset[0]) misalign = 1'b1;
        else           result   = {{(DATA_W-16){half_v[15]}}, half_v};
      end
      EXT_LHU: begin
        if (offset[0]) misalign = 1'b1;
        else           result   = {{(DATA_W-16){1'b0}}, half_v};
      end
      EXT_LW: begin
        if (|offset) misalign = 1'b1;
        else         result   = data;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe
//   Pipelined immediate / load-data extender with a 2-entry skid buffer
//   between the decode/memory-read side and writeback.
//   Ports:
//     i_clk, i_rst_n          - clock, async active-low reset
//     i_valid / o_ready       - upstream handshake
//     i_ext_op, i_data,
//     i_offset, i_tag         - request (op, immediate or load word, byte
//                               offset, destination tag)
//     o_valid / i_ready       - downstream handshake
//     o_data, o_tag,
//     o_misalign              - buffered result
//
//   state | meaning
//   ------+--------------------------------------------------
//   EMPTY | no result held, o_valid=0
//   ONE   | main entry holds the result shown on o_*
//   FULL  | main shown on o_*, skid holds the next result;
//         | upstream is stalled (o_ready=0)
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int IMM_W  = 16,
  parameter  int TAG_W  = 5,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_ext_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_misalign
);

  buf_state_t   state_q;
  ext_payload_t main_q;
  ext_payload_t skid_q;
  ext_payload_t new_pl;

  logic [DATA_W-1:0] calc_data;
  logic              calc_misalign;
  logic              accept;
  logic              pop;

  ext_compute #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .OFF_W  (OFF_W)
  ) u_compute (
    .ext_op   (i_ext_op),
    .data     (i_data),
    .offset   (i_offset),
    .result   (calc_data),
    .misalign (calc_misalign)
  );

  always_comb begin
    new_pl          = '0;
    new_pl.data     = EXT_MAX_DATA_W'(calc_data);
    new_pl.tag      = EXT_MAX_TAG_W'(i_tag);
    new_pl.misalign = calc_misalign;
  end

  assign o_ready = (state_q != FULL);
  assign o_valid = (state_q != EMPTY);
  assign accept  = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= new_pl;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= new_pl;
          end else if (accept) begin
            skid_q  <= new_pl;
            state_q <= FULL;
          end else if (pop) begin
            // Clear so an idle output never shows a stale result.
            main_q  <= '0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign o_data     = main_q.data[DATA_W-1:0];
  assign o_tag      = main_q.tag[TAG_W-1:0];
  assign o_misalign = main_q.misalign;

  // Upper payload bits exist only for the widest configuration.
  logic unused_main;
  assign unused_main = ^main_q;

endmodule
